// File: rtl/writeback_commit_queue.sv
// Dual-lane writeback commit queue: accepts up to two writebacks per cycle and
// retires them one per cycle, in program order, to a single register-file write port.
module writeback_commit_queue #(
    parameter int depth         = 8,
    parameter int regWidth      = 5,
    parameter int dataWidth     = 64,
    parameter int unitCodeWidth = 3
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic [unitCodeWidth-1:0]   functionalUnitCode_i,
    input  logic                       reg1WritebackEnable_i,
    input  logic                       reg2WritebackEnable_i,
    input  logic [regWidth-1:0]        reg1WritebackAddress_i,
    input  logic [regWidth-1:0]        reg2WritebackAddress_i,
    input  logic [dataWidth-1:0]       reg1WritebackVal_i,
    input  logic [dataWidth-1:0]       reg2WritebackVal_i,
    output logic                       stall_o,
    output logic                       regWriteEnable_o,
    output logic [regWidth-1:0]        regWriteAddress_o,
    output logic [dataWidth-1:0]       regWriteVal_o,
    output logic [unitCodeWidth-1:0]   regWriteUnitCode_o,
    output logic                       regWriteLane_o,
    output logic [$clog2(depth):0]     count_o,
    output logic                       overflow_o
);

    localparam int PtrWidth = $clog2(depth);
    localparam int CntWidth = PtrWidth + 1;

    typedef struct packed {
        logic [unitCodeWidth-1:0] unit_code;
        logic [regWidth-1:0]      address;
        logic [dataWidth-1:0]     value;
        logic                     lane;
    } entry_t;

    entry_t                mem_q [depth];
    entry_t                mem_d [depth];
    logic [PtrWidth-1:0]   rd_ptr_q;
    logic [PtrWidth-1:0]   rd_ptr_d;
    logic [PtrWidth-1:0]   wr_ptr_q;
    logic [PtrWidth-1:0]   wr_ptr_d;
    logic [CntWidth-1:0]   count_q;
    logic [CntWidth-1:0]   count_d;
    logic                  overflow_q;
    logic                  overflow_d;

    logic                  pop_s;
    logic [CntWidth-1:0]   space_s;
    logic                  acc1_s;
    logic                  acc2_s;
    logic [1:0]            req_s;
    logic [1:0]            acc_s;
    logic [PtrWidth-1:0]   lane2_ptr_s;
    entry_t                head_s;

    // Next-state: pop from pre-push occupancy, then accept lanes in order up to free space.
    always_comb begin
        pop_s       = (count_q != {CntWidth{1'b0}});
        space_s     = CntWidth'(depth) - count_q + CntWidth'(pop_s);
        acc1_s      = reg1WritebackEnable_i && (space_s != {CntWidth{1'b0}});
        acc2_s      = reg2WritebackEnable_i && (space_s > CntWidth'(acc1_s));
        req_s       = {1'b0, reg1WritebackEnable_i} + {1'b0, reg2WritebackEnable_i};
        acc_s       = {1'b0, acc1_s} + {1'b0, acc2_s};
        // A lone lane 2 lands at the write pointer; otherwise it follows lane 1.
        lane2_ptr_s = wr_ptr_q + PtrWidth'(acc1_s);

        mem_d = mem_q;
        if (acc1_s) begin
            mem_d[wr_ptr_q] = '{unit_code: functionalUnitCode_i,
                                address:   reg1WritebackAddress_i,
                                value:     reg1WritebackVal_i,
                                lane:      1'b0};
        end else begin
            mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
        end
        if (acc2_s) begin
            mem_d[lane2_ptr_s] = '{unit_code: functionalUnitCode_i,
                                   address:   reg2WritebackAddress_i,
                                   value:     reg2WritebackVal_i,
                                   lane:      1'b1};
        end else begin
            mem_d[lane2_ptr_s] = mem_q[lane2_ptr_s];
        end

        wr_ptr_d   = wr_ptr_q + PtrWidth'(acc_s);
        rd_ptr_d   = rd_ptr_q + PtrWidth'(pop_s);
        count_d    = count_q + CntWidth'(acc_s) - CntWidth'(pop_s);
        overflow_d = overflow_q | (acc_s != req_s);
    end

    // Control state with synchronous reset taking priority over push/pop.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rd_ptr_q   <= {PtrWidth{1'b0}};
            wr_ptr_q   <= {PtrWidth{1'b0}};
            count_q    <= {CntWidth{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage; contents are meaningless once the pointers are reset.
    always_ff @(posedge clock_i) begin
        mem_q <= mem_d;
    end

    // Head outputs, forced to zero while the queue is empty.
    always_comb begin
        head_s = mem_q[rd_ptr_q];
        if (count_q != {CntWidth{1'b0}}) begin
            regWriteEnable_o   = 1'b1;
            regWriteAddress_o  = head_s.address;
            regWriteVal_o      = head_s.value;
            regWriteUnitCode_o = head_s.unit_code;
            regWriteLane_o     = head_s.lane;
        end else begin
            regWriteEnable_o   = 1'b0;
            regWriteAddress_o  = {regWidth{1'b0}};
            regWriteVal_o      = {dataWidth{1'b0}};
            regWriteUnitCode_o = {unitCodeWidth{1'b0}};
            regWriteLane_o     = 1'b0;
        end
        // Stall ignores the same-cycle pop so a compliant producer never overflows.
        stall_o    = (count_q >= CntWidth'(depth - 1));
        count_o    = count_q;
        overflow_o = overflow_q;
    end

endmodule
